// File: rtl/cpu_regs_pkg.sv
// Shared widths, context-entry layout and stack-operation encoding for cpu_state_regs.
// With CPU_NFLAG_EN defined, each context entry carries an extra N flag bit.
package cpu_regs_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

`ifdef CPU_NFLAG_EN
  localparam int FLAG_W = 2;
  localparam int N_OFF  = 1;
`else
  localparam int FLAG_W = 1;
`endif

  // Entry layout from LSB upward: flags, then ACC, then PC.
  localparam int Z_OFF   = 0;
  localparam int ACC_OFF = FLAG_W;

  function automatic int ctx_w(input int addr_w, input int data_w);
    return addr_w + data_w + FLAG_W;
  endfunction

  function automatic int pc_off(input int data_w);
    return FLAG_W + data_w;
  endfunction

  localparam int CTX_W = ctx_w(ADDR_W_DEF, DATA_W_DEF);

  typedef enum logic [1:0] {
    CTX_IDLE = 2'b00,
    CTX_POP  = 2'b01,
    CTX_PUSH = 2'b10,
    CTX_BOTH = 2'b11
  } ctx_op_e;

endpackage

// File: rtl/ctx_stack.sv
// Hardware context stack: LIFO storage, saturating occupancy counter,
// full/empty flags and a sticky error for overflow, underflow or push+pop collision.
module ctx_stack #(
  parameter int CTX_W     = cpu_regs_pkg::CTX_W,
  parameter int CTX_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_stall,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [CTX_W-1:0]             i_din,
  output logic [CTX_W-1:0]             o_dout,
  output logic [$clog2(CTX_DEPTH):0]   o_level,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_err,
  output logic                         o_popOk
);
  import cpu_regs_pkg::*;

  localparam int IDX_W = $clog2(CTX_DEPTH);
  localparam int LVL_W = IDX_W + 1;

  logic [CTX_W-1:0] r_mem [CTX_DEPTH];
  logic [LVL_W-1:0] r_level;
  logic             r_err;

  ctx_op_e          w_op;
  logic             w_full;
  logic             w_empty;
  logic             w_doPush;
  logic             w_doPop;
  logic             w_errEvt;
  logic [IDX_W-1:0] w_wrIdx;
  logic [IDX_W-1:0] w_rdIdx;

  assign w_op    = ctx_op_e'({i_push, i_pop});
  assign w_full  = (r_level == LVL_W'(CTX_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_wrIdx = r_level[IDX_W-1:0];
  assign w_rdIdx = w_wrIdx - IDX_W'(1);

  always_comb begin
    w_doPush = 1'b0;
    w_doPop  = 1'b0;
    w_errEvt = 1'b0;
    if (!i_stall) begin
      case (w_op)
        CTX_PUSH: if (w_full)  w_errEvt = 1'b1; else w_doPush = 1'b1;
        CTX_POP:  if (w_empty) w_errEvt = 1'b1; else w_doPop  = 1'b1;
        CTX_BOTH: w_errEvt = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_doPush)
        r_level <= r_level + LVL_W'(1);
      else if (w_doPop)
        r_level <= r_level - LVL_W'(1);
      if (w_errEvt)
        r_err <= 1'b1;
    end
  end

  // Storage is deliberately left uncleared on reset; only the level defines validity.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_doPush)
      r_mem[w_wrIdx] <= i_din;
  end

  assign o_dout  = r_mem[w_rdIdx];
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_err   = r_err;
  assign o_popOk = w_doPop;

endmodule

// File: rtl/cpu_state_regs.sv
// CPU architectural register bank with per-register enables, global stall and a context stack.
// Define CPU_NFLAG_EN to add the N flag (ports N_we, Nflag_next, Nflag_reg) and save it in contexts.
module cpu_state_regs
  import cpu_regs_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CTX_DEPTH = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Stall,
  input  logic                        PC_we,
  input  logic                        IR_we,
  input  logic                        ACC_we,
  input  logic                        MDR_we,
  input  logic                        MAR_we,
  input  logic                        Z_we,
  input  logic [ADDR_W-1:0]           PC_next,
  input  logic [DATA_W-1:0]           IR_next,
  input  logic [DATA_W-1:0]           ACC_next,
  input  logic [DATA_W-1:0]           MDR_next,
  input  logic [ADDR_W-1:0]           MAR_next,
  input  logic                        Zflag_next,
`ifdef CPU_NFLAG_EN
  input  logic                        N_we,
  input  logic                        Nflag_next,
  output logic                        Nflag_reg,
`endif
  input  logic                        Ctx_push,
  input  logic                        Ctx_pop,
  output logic [ADDR_W-1:0]           PC_reg,
  output logic [ADDR_W-1:0]           MAR_reg,
  output logic [DATA_W-1:0]           IR_reg,
  output logic [DATA_W-1:0]           ACC_reg,
  output logic [DATA_W-1:0]           MDR_reg,
  output logic                        Zflag_reg,
  output logic                        Ctx_empty,
  output logic                        Ctx_full,
  output logic [$clog2(CTX_DEPTH):0]  Ctx_level,
  output logic                        Ctx_err
);

  localparam int CW     = ctx_w(ADDR_W, DATA_W);
  localparam int PC_OFF = pc_off(DATA_W);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mdr;
  logic              r_z;
  logic [CW-1:0]     w_din;
  logic [CW-1:0]     w_dout;
  logic              w_popOk;

`ifdef CPU_NFLAG_EN
  logic r_n;
  assign w_din     = {r_pc, r_acc, r_n, r_z};
  assign Nflag_reg = r_n;
`else
  assign w_din = {r_pc, r_acc, r_z};
`endif

  ctx_stack #(
    .CTX_W     (CW),
    .CTX_DEPTH (CTX_DEPTH)
  ) u_ctxStack (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_stall (Stall),
    .i_push  (Ctx_push),
    .i_pop   (Ctx_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_level (Ctx_level),
    .o_full  (Ctx_full),
    .o_empty (Ctx_empty),
    .o_err   (Ctx_err),
    .o_popOk (w_popOk)
  );

  // An accepted pop restores the saved context and overrides the normal PC/ACC/flag loads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_acc <= '0;
      r_mdr <= '0;
      r_mar <= '0;
      r_z   <= 1'b0;
`ifdef CPU_NFLAG_EN
      r_n   <= 1'b0;
`endif
    end else if (!Stall) begin
      if (w_popOk) begin
        r_pc  <= w_dout[PC_OFF +: ADDR_W];
        r_acc <= w_dout[ACC_OFF +: DATA_W];
        r_z   <= w_dout[Z_OFF];
`ifdef CPU_NFLAG_EN
        r_n   <= w_dout[N_OFF];
`endif
      end else begin
        if (PC_we)  r_pc  <= PC_next;
        if (ACC_we) r_acc <= ACC_next;
        if (Z_we)   r_z   <= Zflag_next;
`ifdef CPU_NFLAG_EN
        if (N_we)   r_n   <= Nflag_next;
`endif
      end
      if (IR_we)  r_ir  <= IR_next;
      if (MDR_we) r_mdr <= MDR_next;
      if (MAR_we) r_mar <= MAR_next;
    end
  end

  assign PC_reg    = r_pc;
  assign IR_reg    = r_ir;
  assign ACC_reg   = r_acc;
  assign MDR_reg   = r_mdr;
  assign MAR_reg   = r_mar;
  assign Zflag_reg = r_z;

endmodule
